inst_mem_prog: RTL and testbench
================================

# inst_mem_prog

Parametrised, loadable instruction memory for the filter processor. It replaces the fixed 256×16 boot-image ROM with a RAM that clears itself after reset, is programmed through a loader handshake, and serves registered fetches to the PC stage. Fetching stops on a halt word, on the last address, or on an out-of-range address.

## Interface
- DATA_W, 16, instruction width
- ADDR_W, 8, memory address width; DEPTH = 2**ADDR_W
- FILL_WORD, 16'hFFFF, value written to every location during clear
- HALT_WORD, 16'hFFFF, fetched value that ends a run
- HALT_EN, 1, 1 = HALT_WORD ends a run; 0 = only last-address or fault ends it

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_load_valid  in  1  loader write request
- i_load_addr  in  ADDR_W  write address
- i_load_data  in  DATA_W  write data
- o_load_ready  out  1  write accepted this cycle when high with i_load_valid
- i_start  in  1  one-cycle pulse; begins a run
- i_fetch_req  in  1  fetch request
- i_dir  in  32  fetch address (processor PC)
- o_dir  out  DATA_W  fetched instruction
- o_dir_valid  out  1  o_dir updated this cycle
- o_busy  out  1  clear in progress
- o_done  out  1  run ended; level
- o_fault  out  1  one-cycle pulse for out-of-range fetch

## Operation
- States: CLEAR, IDLE, RUN, DONE.
- CLEAR (entered on rst): writes FILL_WORD at clear_ptr and increments clear_ptr from 0 to DEPTH-1, one word per cycle. After writing DEPTH-1, goes to IDLE. o_busy=1. Loads and fetches are ignored.
- IDLE: o_load_ready=1. A write happens when i_load_valid=1. i_start moves the block to RUN. Fetch requests are ignored.
- RUN: o_load_ready=0 and loads are dropped. A fetch happens when i_fetch_req=1:
  - i_dir < DEPTH: o_dir = mem[i_dir].
  - i_dir >= DEPTH: o_dir = FILL_WORD, o_fault pulses, and the state goes to DONE.
  - Whether or not it faults, the fetched word is delivered (o_dir_valid=1).
  - Go to DONE after the fetch if i_dir == DEPTH-1, or if HALT_EN=1 and the word equals HALT_WORD. The ending word is still delivered.
- DONE: o_done=1, o_dir holds its last value, and fetches are ignored. i_start returns to RUN with o_done cleared and the memory contents kept. Loads are accepted (o_load_ready=1), so the program can be patched before a re-run.
- Reset at any point, including mid-CLEAR, restarts CLEAR from address 0.

## Timing
- Reset values: o_dir=0, o_dir_valid=0, o_busy=1, o_done=0, o_fault=0, o_load_ready=0.
- CLEAR lasts exactly DEPTH cycles after the rst-deasserted edge. o_busy falls and o_load_ready rises on the same edge that enters IDLE.
- Load write commits at the clock edge with i_load_valid & o_load_ready. A fetch of that address in any later cycle returns the new data.
- Fetch latency is 1 cycle: request at edge N gives o_dir/o_dir_valid at edge N+1. Back-to-back fetches give one word per cycle.
- o_done rises at the same edge as the ending word's o_dir_valid. o_fault behaves the same way.
- An i_start in the same cycle as a load in IDLE: the write commits and the block enters RUN. A fetch in the next cycle sees the written data.
- i_fetch_req in the start cycle is ignored; the first valid fetch is the cycle after entering RUN.
- i_start in RUN or CLEAR is ignored.
- Only the low ADDR_W bits index memory. The range check uses all 32 bits of i_dir.

## Test plan
- Reset clear: rst 1 cycle with default params. Expect o_busy=1 for exactly 256 cycles, then o_load_ready=1. A fetch after start at addr 40 returns 16'hFFFF with o_done=1.
- Load and run: load 16'hb300, 16'hb200, 16'hb101, 16'h8b11 at 0–3, then pulse i_start and fetch 0,1,2,3,4 back-to-back. Expect those four words at 1-cycle latency, then 16'hFFFF at addr 4 with o_done rising on the same edge.
- Last address: HALT_EN=0, fetch addr 255 holding 16'h1234. Expect o_dir=16'h1234 and o_done=1. A further fetch of addr 0 gives no o_dir_valid.
- Fault: in RUN, fetch i_dir=300. Expect o_dir=16'hFFFF, o_fault high for 1 cycle, and o_done=1.
- Load blocking: i_load_valid to addr 2 with 16'hAAAA during RUN. Expect o_load_ready=0 and a later fetch of addr 2 unchanged. Repeat in DONE, then re-start: expect 16'hAAAA.
- Reset mid-operation: rst during CLEAR at cycle 100 and again mid-RUN. Expect full 256-cycle clear each time and all outputs at their reset values.

Source files
------------

// File: rtl/inst_mem_prog.sv
// inst_mem_prog: loadable instruction RAM for the filter processor.
// Self-clears to FILL_WORD after reset, accepts loader writes while idle or
// done, and serves one registered fetch per cycle while running. A run ends
// on HALT_WORD (when enabled), on the last address, or on an out-of-range fetch.
`timescale 1ns/1ps
module inst_mem_prog #(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 8,
    parameter logic [DATA_W-1:0] FILL_WORD = 16'hFFFF,
    parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF,
    parameter bit              HALT_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_valid,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    input  logic              i_start,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_dir,
    output logic [DATA_W-1:0] o_dir,
    output logic              o_dir_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fault
);

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
    logic [DATA_W-1:0]   dir_q;
    logic                dir_valid_q;
    logic                fault_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                fetch_en;
    logic                in_range;
    logic [DATA_W-1:0]   fetch_word;
    logic                run_end;

    // Fetch address decode: the range check sees all 32 PC bits, only the low bits index the RAM.
    always_comb begin
        in_range   = ({1'b0, i_dir} < DEPTH_EXT);
        fetch_word = in_range ? mem[i_dir[ADDR_W-1:0]] : FILL_WORD;
        run_end    = !in_range
                     || (i_dir[ADDR_W-1:0] == {ADDR_W{1'b1}})
                     || (HALT_EN && (fetch_word == HALT_WORD));
    end

    // Next-state, write-port selection and status outputs.
    always_comb begin
        state_d      = state_q;
        clear_ptr_d  = clear_ptr_q;
        we           = 1'b0;
        waddr        = i_load_addr;
        wdata        = i_load_data;
        fetch_en     = 1'b0;
        o_busy       = 1'b0;
        o_load_ready = 1'b0;
        o_done       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                o_busy      = 1'b1;
                we          = 1'b1;
                waddr       = clear_ptr_q;
                wdata       = FILL_WORD;
                clear_ptr_d = clear_ptr_q + ADDR_W'(1);
                if (clear_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                o_load_ready = 1'b1;
                we           = i_load_valid;
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_fetch_req) begin
                    fetch_en = 1'b1;
                    if (run_end) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_load_ready = 1'b1;
                o_done       = 1'b1;
                we           = i_load_valid;
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Control state and registered fetch outputs; reset restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            dir_q       <= '0;
            dir_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            dir_valid_q <= fetch_en;
            fault_q     <= fetch_en && !in_range;
            if (fetch_en) begin
                dir_q <= fetch_word;
            end
        end
    end

    // Single write port shared by the clear sweep and the loader.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    assign o_dir       = dir_q;
    assign o_dir_valid = dir_valid_q;
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_inst_mem_prog.sv
// Bench for inst_mem_prog: fetch results are predicted from a shadow memory
// and queued; a negedge monitor pops and compares every delivered word.
`timescale 1ns/1ps
module tb_inst_mem_prog;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_load_valid;
    logic [7:0]  i_load_addr;
    logic [15:0] i_load_data;
    logic        i_start;
    logic        i_fetch_req;
    logic [31:0] i_dir;

    logic        o_load_ready, o_dir_valid, o_busy, o_done, o_fault;
    logic [15:0] o_dir;
    logic        o2_load_ready, o2_dir_valid, o2_busy, o2_done, o2_fault;
    logic [15:0] o2_dir;

    typedef struct packed {
        logic [15:0] data;
        logic        done;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem_m [DEPTH];
    bit          run_m;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    inst_mem_prog dut (
        .clk(clk), .rst(rst),
        .i_load_valid(i_load_valid), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .o_load_ready(o_load_ready), .i_start(i_start), .i_fetch_req(i_fetch_req),
        .i_dir(i_dir), .o_dir(o_dir), .o_dir_valid(o_dir_valid), .o_busy(o_busy),
        .o_done(o_done), .o_fault(o_fault)
    );

    inst_mem_prog #(.HALT_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst),
        .i_load_valid(i_load_valid), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .o_load_ready(o2_load_ready), .i_start(i_start), .i_fetch_req(i_fetch_req),
        .i_dir(i_dir), .o_dir(o2_dir), .o_dir_valid(o2_dir_valid), .o_busy(o2_busy),
        .o_done(o2_done), .o_fault(o2_fault)
    );

    // Scoreboard monitor: every delivered word must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (o_dir_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fetch: o_dir=%h o_dir_valid=1, required no delivery", o_dir);
            end else begin
                e = sb_q.pop_front();
                if ({o_dir, o_done, o_fault} !== {e.data, e.done, e.fault}) begin
                    errors++;
                    $display("FAIL fetch_word: dir=%h done=%b fault=%b, required dir=%h done=%b fault=%b",
                             o_dir, o_done, o_fault, e.data, e.done, e.fault);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int abort_at);
        int n;
        rst = 1'b1;
        step();
        checks++;
        if ({o_dir, o_dir_valid, o_busy, o_done, o_fault, o_load_ready} !== {16'h0000, 5'b01000}) begin
            errors++;
            $display("FAIL reset_values: dir=%h vld=%b busy=%b done=%b fault=%b rdy=%b, required 0000 0 1 0 0 0",
                     o_dir, o_dir_valid, o_busy, o_done, o_fault, o_load_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'hFFFF;
        run_m = 1'b0;
        n = 0;
        while (o_busy === 1'b1 && n < 1000 && (abort_at == 0 || n < abort_at)) begin
            step();
            n++;
        end
        if (abort_at == 0) begin
            checks++;
            if (n != DEPTH) begin
                errors++;
                $display("FAIL clear_length: busy cycles=%0d, required %0d", n, DEPTH);
            end
            checks++;
            if (o_load_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_clear: o_load_ready=%b, required 1", o_load_ready);
            end
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d, input logic exp_ready);
        i_load_valid = 1'b1;
        i_load_addr  = a;
        i_load_data  = d;
        checks++;
        if (o_load_ready !== exp_ready) begin
            errors++;
            $display("FAIL load_ready: o_load_ready=%b, required %b", o_load_ready, exp_ready);
        end
        if (exp_ready) mem_m[a] = d;
        step();
        i_load_valid = 1'b0;
    endtask

    task automatic start(input bit with_fetch);
        i_start = 1'b1;
        if (with_fetch) begin
            i_fetch_req = 1'b1;
            i_dir       = 32'd0;
        end
        step();
        i_start     = 1'b0;
        i_fetch_req = 1'b0;
        run_m       = 1'b1;
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL start_done: o_done=%b, required 0", o_done);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        exp_t        e;
        logic [15:0] w;
        bit          inr;
        i_fetch_req = 1'b1;
        i_dir       = a;
        if (run_m) begin
            inr     = (a < 32'(DEPTH));
            w       = inr ? mem_m[a[7:0]] : 16'hFFFF;
            e.data  = w;
            e.fault = !inr;
            e.done  = !inr || (a == 32'(DEPTH - 1)) || (w == 16'hFFFF);
            sb_q.push_back(e);
            if (e.done) run_m = 1'b0;
        end
        step();
        i_fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        start(0);
        fetch(32'd40);
    endtask

    task automatic test_load_run();
        load(8'd0, 16'hb300, 1'b1);
        load(8'd1, 16'hb200, 1'b1);
        load(8'd2, 16'hb101, 1'b1);
        load(8'd3, 16'h8b11, 1'b1);
        start(1);
        for (int a = 0; a < 5; a++) fetch(32'(a));
    endtask

    task automatic test_fault_and_block();
        start(0);
        load(8'd2, 16'hAAAA, 1'b0);
        fetch(32'd2);
        fetch(32'd300);
        step();
        checks++;
        if ({o_fault, o_done} !== 2'b01) begin
            errors++;
            $display("FAIL fault_pulse: fault=%b done=%b, required fault=0 done=1", o_fault, o_done);
        end
        load(8'd2, 16'hAAAA, 1'b1);
        fetch(32'd2);
        start(0);
        fetch(32'd2);
    endtask

    task automatic test_last_addr();
        do_reset(0);
        load(8'd255, 16'h1234, 1'b1);
        start(0);
        fetch(32'd255);
        checks++;
        if ({o2_dir, o2_dir_valid, o2_done} !== {16'h1234, 2'b11}) begin
            errors++;
            $display("FAIL last_addr_nohalt: dir=%h vld=%b done=%b, required 1234 1 1", o2_dir, o2_dir_valid, o2_done);
        end
        fetch(32'd0);
        checks++;
        if ({o_dir_valid, o2_dir_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_in_done: vld=%b vld_nohalt=%b, required 0 0", o_dir_valid, o2_dir_valid);
        end
        start(0);
        fetch(32'd5);
        checks++;
        if ({o2_dir, o2_dir_valid, o2_done} !== {16'hFFFF, 2'b10}) begin
            errors++;
            $display("FAIL halt_disabled: dir=%h vld=%b done=%b, required ffff 1 0", o2_dir, o2_dir_valid, o2_done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(100);
        do_reset(0);
        load(8'd1, 16'h1357, 1'b1);
        start(0);
        fetch(32'd1);
        do_reset(0);
        start(0);
        fetch(32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        i_load_valid = 1'b0;
        i_load_addr  = '0;
        i_load_data  = '0;
        i_start      = 1'b0;
        i_fetch_req  = 1'b0;
        i_dir        = '0;
        run_m        = 1'b0;
        test_reset();
        test_load_run();
        test_fault_and_block();
        test_last_addr();
        test_reset_mid();
        step();
        step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_fetch: %0d predicted words never delivered, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
